// File: rtl/instr_encoder_loader.sv
// Packs RV32I I-type / S-type fields into an instruction word and writes it
// into instruction memory at an auto-incrementing word address.
module instr_encoder_loader #(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic              accept;
    logic              fmt_ok;
    logic              imm_ok;
    logic              is_store;
    logic [31:0]       enc;

    // Handshake: a bundle transfers on a rising edge where in_valid && in_ready
    // and clear is low; in_ready depends only on state, never on in_valid.
    assign full      = (count_q == DEPTH_C);
    assign in_ready  = (state_q == S_IDLE) && !full;
    assign accept    = in_valid && in_ready && !clear;

    assign fmt_ok    = (fmt == 3'b000) || (fmt == 3'b001) || (fmt == 3'b010);
    // In range for a 12-bit signed field when bits 31..11 are all copies of the sign.
    assign imm_ok    = (&imm[31:11]) || !(|imm[31:11]);
    assign is_store  = (fmt == 3'b010);
    assign enc       = is_store ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
                                : {imm[11:0], rs1, funct3, rd, opcode};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        code_d  = code_q;
        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            err_d   = 1'b0;
            code_d  = 2'b00;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (!fmt_ok) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                            code_d  = 2'b01;
                        end else if (!imm_ok) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                            code_d  = 2'b10;
                        end else begin
                            state_d = S_WRITE;
                            wdata_d = enc;
                        end
                    end
                end
                S_WRITE: begin
                    state_d = S_IDLE;
                    count_d = count_q + ONE_C;
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // The strobe comes straight from the state register so reset kills it at once.
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = count_q[ADDR_W-1:0];
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a 4-word memory so the full
// condition is reachable; every memory write is matched against exp_q.
module tb_instr_encoder_loader;

    localparam int MEM_DEPTH = 4;
    localparam int ADDR_W    = 2;
    localparam int EW        = ADDR_W + 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              clear;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    instr_encoder_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .clear(clear), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .full(full), .err(err), .err_code(err_code), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: each observed write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(mem_addr), 32'(e[EW-1:32]));
                check_eq("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Presents one bundle, waits (bounded) for in_ready, and returns 1 ns after
    // the accepting edge. With hold set, in_valid stays high afterwards.
    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] im, input bit hold);
        int n;
        fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!in_ready) check_eq("ready_timeout", 32'd0, 32'd1);
        tick(1);
        if (!hold) in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] b2b_words [4];
        b2b_words[0] = 32'h00100093;
        b2b_words[1] = 32'h00200113;
        b2b_words[2] = 32'h00300193;
        b2b_words[3] = 32'h00400213;

        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        fmt = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        tick(3);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_full", {31'd0, full}, 32'd0);

        // ADDI x1, x0, 5
        expect_write(2'd0, 32'h00500093);
        drive(3'b000, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd9, 32'd5, 1'b0);
        check_eq("addi_we", {31'd0, mem_we}, 32'd1);
        check_eq("addi_busy", {31'd0, in_ready}, 32'd0);
        tick(1);
        check_eq("addi_we_one", {31'd0, mem_we}, 32'd0);
        check_eq("addi_count", 32'(count), 32'd1);
        check_eq("wdata_hold", mem_wdata, 32'h00500093);

        // LW x5, 8(x2)
        expect_write(2'd1, 32'h00812283);
        drive(3'b001, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'd8, 1'b0);
        tick(1);
        check_eq("lw_count", 32'(count), 32'd2);

        // SW x2, -4(x3), then SW at imm=-2048; rd is ignored for stores
        expect_write(2'd2, 32'hFE21AE23);
        drive(3'b010, 7'b0100011, 3'b010, 5'd31, 5'd3, 5'd2, 32'hFFFFFFFC, 1'b0);
        tick(1);
        expect_write(2'd3, 32'h8021A023);
        drive(3'b010, 7'b0100011, 3'b010, 5'd31, 5'd3, 5'd2, 32'hFFFFF800, 1'b0);
        tick(1);
        check_eq("fill_count", 32'(count), 32'd4);
        check_eq("fill_full", {31'd0, full}, 32'd1);
        check_eq("fill_ready", {31'd0, in_ready}, 32'd0);
        check_eq("fill_err", {31'd0, err}, 32'd0);

        // Valid bundle while full is dropped silently
        in_valid = 1'b1;
        tick(4);
        in_valid = 1'b0;
        check_eq("full_hold_count", 32'(count), 32'd4);
        check_eq("full_no_err", {31'd0, err}, 32'd0);

        clear = 1'b1; tick(1); clear = 1'b0;
        check_eq("clr_count", 32'(count), 32'd0);
        check_eq("clr_full", {31'd0, full}, 32'd0);
        check_eq("clr_ready", {31'd0, in_ready}, 32'd1);

        // ADDI x1, x0, 2047; rs2 is ignored for I formats
        expect_write(2'd0, 32'h7FF00093);
        drive(3'b000, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd7, 32'd2047, 1'b0);
        tick(1);
        check_eq("max_count", 32'(count), 32'd1);
        check_eq("max_err", {31'd0, err}, 32'd0);

        // imm=2048 is out of range
        drive(3'b000, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        check_eq("oor_we", {31'd0, mem_we}, 32'd0);
        check_eq("oor_err", {31'd0, err}, 32'd1);
        check_eq("oor_code", 32'(err_code), 32'd2);
        check_eq("oor_ready", {31'd0, in_ready}, 32'd0);
        check_eq("oor_state", 32'(dbg_state), 32'd2);
        fmt = 3'b011; in_valid = 1'b1;
        tick(2);
        in_valid = 1'b0;
        check_eq("err_sticky_code", 32'(err_code), 32'd2);
        check_eq("err_count", 32'(count), 32'd1);
        clear = 1'b1; tick(1); clear = 1'b0;
        check_eq("eclr_err", {31'd0, err}, 32'd0);
        check_eq("eclr_code", 32'(err_code), 32'd0);
        check_eq("eclr_count", 32'(count), 32'd0);
        check_eq("eclr_ready", {31'd0, in_ready}, 32'd1);

        // Illegal fmt wins over bad imm
        drive(3'b011, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        check_eq("fmt_code", 32'(err_code), 32'd1);
        check_eq("fmt_err", {31'd0, err}, 32'd1);
        clear = 1'b1; tick(1); clear = 1'b0;

        // imm=-2049 is out of range on the negative side
        drive(3'b001, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'hFFFFF7FF, 1'b0);
        check_eq("neg_oor_code", 32'(err_code), 32'd2);
        clear = 1'b1; tick(1); clear = 1'b0;

        // Bundle presented together with clear is not accepted
        fmt = 3'b000; opcode = 7'b0010011; imm = 32'd5;
        in_valid = 1'b1; clear = 1'b1;
        tick(1);
        in_valid = 1'b0; clear = 1'b0;
        check_eq("clr_acc_we", {31'd0, mem_we}, 32'd0);
        check_eq("clr_acc_state", 32'(dbg_state), 32'd0);

        // Clear during WRITE: strobe still happens, count returns to 0
        expect_write(2'd0, 32'h00500093);
        drive(3'b000, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        clear = 1'b1; tick(1); clear = 1'b0;
        check_eq("clr_wr_count", 32'(count), 32'd0);
        check_eq("clr_wr_we", {31'd0, mem_we}, 32'd0);

        // Back-to-back: in_valid held high, writes on alternate cycles
        for (int i = 0; i < 4; i++) begin
            expect_write(ADDR_W'(i), b2b_words[i]);
            drive(3'b000, 7'b0010011, 3'b000, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1), 1'b1);
            check_eq("b2b_we", {31'd0, mem_we}, 32'd1);
            check_eq("b2b_addr", 32'(mem_addr), 32'(i));
        end
        tick(1);
        check_eq("b2b_full", {31'd0, full}, 32'd1);
        check_eq("b2b_ready", {31'd0, in_ready}, 32'd0);
        check_eq("b2b_count", 32'(count), 32'd4);
        tick(4);
        in_valid = 1'b0;
        check_eq("b2b_fifth_count", 32'(count), 32'd4);

        // Async reset in the middle of the WRITE cycle
        clear = 1'b1; tick(1); clear = 1'b0;
        drive(3'b000, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        check_eq("pre_rst_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_wdata", mem_wdata, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        expect_write(2'd0, 32'h00812283);
        drive(3'b001, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'd8, 1'b0);
        tick(1);
        check_eq("post_rst_count", 32'(count), 32'd1);

        tick(2);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
